rs485_txn_ctrl: RTL and testbench
=================================

RS485_TXN_CTRL -- requirements
Module: rs485_txn_ctrl

Interface
REQ-001 SHALL have parameter G_BUF_DEPTH, default 16, payload bytes per direction.
REQ-002 SHALL have parameter G_TMO_CYCLES, default 1280000, response timeout in p_in_clk cycles (10 ms at 128 MHz).
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 p_in_clk  in  1  system clock, 128 MHz.
REQ-005 p_in_rst_n  in  1  synchronous active-low reset.
REQ-006 p_in_start  in  1  one-cycle pulse that starts a transaction.
REQ-007 p_in_dev_adr  in  8  device address.
REQ-008 p_in_dev_cmd  in  8  device command.
REQ-009 p_in_tx_len  in  5  payload byte count, 0..16.
REQ-010 p_in_txbuf_wr, p_in_txbuf_adr[3:0], p_in_txbuf_d[7:0]  in  host write port into the TX payload buffer.
REQ-011 p_out_txd_rdy  out  1  byte available to the link.
REQ-012 p_out_txd  out  8  current byte to the link.
REQ-013 p_in_txd_rd  in  1  one-cycle pulse; the link consumed p_out_txd.
REQ-014 p_in_rxd  in  8  received byte from the link.
REQ-015 p_in_rxd_wr  in  1  one-cycle strobe qualifying p_in_rxd.
REQ-016 p_in_link_status  in  3  link status: 0 busy, 1 RX OK, 2 RX parity error.
REQ-017 p_in_rxbuf_adr  in  4  host read address into the RX payload buffer.
REQ-018 p_out_rxbuf_d  out  8  RX buffer data, registered, 1-cycle latency.
REQ-019 p_out_rx_len  out  5  number of RX payload bytes stored.
REQ-020 p_out_busy  out  1  high from start accepted until done.
REQ-021 p_out_done  out  1  one-cycle pulse at transaction end.
REQ-022 p_out_result  out  3  0 OK, 1 parity, 2 address mismatch, 3 command mismatch, 4 timeout, 5 RX overflow, 6 short response; valid with done and held until the next start.

Function
REQ-023 SHALL use FSM states S_IDLE, S_TX, S_WAIT_ARM, S_WAIT_RSP, S_DONE.
REQ-024 S_IDLE: p_in_start latches adr, cmd and min(tx_len,16); clears rx_len; sets busy; goes to S_TX on the next cycle. p_in_start while busy SHALL be ignored.
REQ-025 S_TX byte order SHALL be adr, cmd, then payload[0..len-1]; total 2+len bytes.
REQ-026 S_TX handshake:
- txd_rdy=1 with p_out_txd stable.
- Each p_in_txd_rd advances the byte index; the next byte is presented on the following cycle.
- On the rd of the last byte, txd_rdy SHALL be 0 in the next cycle and the FSM goes to S_WAIT_ARM.
- p_in_txd_rd while txd_rdy=0 SHALL be ignored.
REQ-027 S_WAIT_ARM: link_status==0 observed moves to S_WAIT_RSP. This discards the previous transaction's held status.
REQ-028 S_WAIT_RSP, on each rxd_wr:
- Byte 0 is compared against adr; a mismatch sets a sticky err=2.
- Byte 1 is compared against cmd; a mismatch sets err=3, unless an earlier error is already set.
- Bytes 2+ are written to the RX buffer at index rx_len, and rx_len increments.
- A 17th payload byte SHALL NOT be written and sets err=5.
REQ-029 S_WAIT_RSP, link_status != 0 terminates the response and the FSM goes to S_DONE. Result priority:
- status 2 gives result 1;
- otherwise the sticky error, if one is set;
- otherwise fewer than 2 bytes received gives 6;
- otherwise 0.
REQ-030 An rxd_wr and a nonzero link_status in the same cycle SHALL count the byte first.
REQ-031 S_DONE: done=1 for one cycle, busy=0, return to S_IDLE.
REQ-032 The TX buffer SHALL be writable at any time; writes during S_TX affect unsent bytes (host responsibility).
REQ-033 RX buffer read data SHALL be valid one cycle after p_in_rxbuf_adr changes; rx_len saturates at 16.

Reset
REQ-034 With p_in_rst_n=0 at a clock edge, the block SHALL enter S_IDLE with:
- txd_rdy=0, txd=0;
- busy=0, done=0;
- result=0, rx_len=0;
- timeout counter cleared.
REQ-035 Reset mid-transaction SHALL abort with no done pulse; buffer contents are undefined after reset.

Configuration
REQ-036 With RS485_TXN_TMO_EN defined:
- A counter runs in S_WAIT_ARM and S_WAIT_RSP, cleared on each rxd_wr.
- Reaching G_TMO_CYCLES-1 goes to S_DONE with result 4.
REQ-037 Without RS485_TXN_TMO_EN, no counter SHALL exist, result 4 is never produced, and the block waits indefinitely.

Structure
REQ-038 Package rs485_txn_pkg SHALL hold the state encoding, the result codes, the link-status codes (0, 1, 2) and the buffer-depth constant.
REQ-039 Sub-module rs485_txn_buf SHALL be a 16x8 simple dual-port RAM with registered read, instantiated twice (TX and RX).

Verification
REQ-040 Each scenario below SHALL be covered by a directed bench test:
- adr=0x21, cmd=0x05, len=2, payload 0xAA,0x55: link rd sequence yields 21,05,AA,55 and txd_rdy falls 1 cycle after the 4th rd. Response 21,05,0F then status 1 gives done, result 0, rx_len 1, rxbuf[0]=0x0F.
- Response 22,05,... then status 1 gives result 2. Response 21,06 then status 1 gives result 3.
- Held status 1 from the previous transaction stays asserted until a 0 is seen: no premature done. Status 2 after bytes gives result 1.
- 19 bytes received (21,05 plus 17 payload) gives result 5, rx_len 16, and the 17th payload byte is not stored.
- Status 1 with only adr received gives result 6. With the macro on and no response, done occurs G_TMO_CYCLES cycles after S_WAIT_ARM with result 4.
- Start while busy is ignored. Reset asserted during S_TX drops txd_rdy, gives no done, and a subsequent start works normally.

Source files
------------

// File: rtl/rs485_txn_pkg.sv
// ---------------------------------------------------------------------------
// rs485_txn_pkg
// Shared definitions for the RS-485 transaction controller:
//   - FSM state encoding
//   - transaction result codes
//   - link status codes reported by the byte link
//   - payload buffer geometry
//   - small helpers for length clamping and result selection
// ---------------------------------------------------------------------------
package rs485_txn_pkg;

    localparam int LP_BUF_DEPTH = 16;
    localparam int LP_BUF_ADR_W = 4;
    localparam int LP_BYTE_W    = 8;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_TX       = 3'd1,
        S_WAIT_ARM = 3'd2,
        S_WAIT_RSP = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        RES_OK     = 3'd0,
        RES_PARITY = 3'd1,
        RES_ADR    = 3'd2,
        RES_CMD    = 3'd3,
        RES_TMO    = 3'd4,
        RES_OVF    = 3'd5,
        RES_SHORT  = 3'd6
    } result_t;

    localparam logic [2:0] LS_BUSY    = 3'd0;
    localparam logic [2:0] LS_RX_OK   = 3'd1;
    localparam logic [2:0] LS_RX_PERR = 3'd2;

    // Payload length limited to the buffer depth.
    function automatic logic [4:0] clamp_len(input logic [4:0] len,
                                             input logic [4:0] max_len);
        return (len > max_len) ? max_len : len;
    endfunction

    // Final result when the link ends a response. A parity error from the
    // link outranks anything seen in the bytes; a sticky byte error outranks
    // a short response.
    function automatic logic [2:0] resolve_result(input logic [2:0] status,
                                                  input logic [2:0] err,
                                                  input logic [1:0] hdr_cnt);
        logic [2:0] res;
        if (status == LS_RX_PERR)
            res = RES_PARITY;
        else if (err != RES_OK)
            res = err;
        else if (hdr_cnt < 2'd2)
            res = RES_SHORT;
        else
            res = RES_OK;
        return res;
    endfunction

endpackage

// File: rtl/rs485_txn_buf.sv
// ---------------------------------------------------------------------------
// rs485_txn_buf
// 16 x 8 simple dual-port RAM: one synchronous write port, one read port
// with registered output (data valid one clock after the read address).
// Contents are not reset.
//
// Ports:
//   p_in_clk   clock
//   i_wr       write enable
//   i_wadr     write address
//   i_wd       write data
//   i_radr     read address
//   o_rd       registered read data
// ---------------------------------------------------------------------------
module rs485_txn_buf
    import rs485_txn_pkg::*;
(
    input  logic                    p_in_clk,
    input  logic                    i_wr,
    input  logic [LP_BUF_ADR_W-1:0] i_wadr,
    input  logic [LP_BYTE_W-1:0]    i_wd,
    input  logic [LP_BUF_ADR_W-1:0] i_radr,
    output logic [LP_BYTE_W-1:0]    o_rd
);

    logic [LP_BYTE_W-1:0] r_mem [LP_BUF_DEPTH];

    always_ff @(posedge p_in_clk) begin
        if (i_wr)
            r_mem[i_wadr] <= i_wd;
        o_rd <= r_mem[i_radr];
    end

endmodule

// File: rtl/rs485_txn_ctrl.sv
// ---------------------------------------------------------------------------
// rs485_txn_ctrl
// Host-side RS-485 request/response sequencer. A start pulse sends
// address, command and up to 16 payload bytes to the byte link, then
// collects and checks the response, storing its payload in the RX buffer.
//
// Optional feature macro: RS485_TXN_TMO_EN
//   defined   - response timeout counter, result 4 on expiry
//   undefined - no counter, block waits for the link indefinitely
//
// Ports:
//   p_in_clk, p_in_rst_n           clock, synchronous active-low reset
//   p_in_start                     start pulse (ignored while busy)
//   p_in_dev_adr/cmd/tx_len        transaction header and payload length
//   p_in_txbuf_wr/adr/d            host write port of the TX buffer
//   p_out_txd_rdy, p_out_txd       byte offered to the link
//   p_in_txd_rd                    link consumed p_out_txd
//   p_in_rxd, p_in_rxd_wr          received byte and strobe
//   p_in_link_status               0 busy, 1 RX OK, 2 RX parity error
//   p_in_rxbuf_adr, p_out_rxbuf_d  host read port of the RX buffer
//   p_out_rx_len                   payload bytes stored
//   p_out_busy, p_out_done         transaction status
//   p_out_result                   result code, held until next start
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | waiting for start
// S_TX       | offering adr, cmd, payload to the link
// S_WAIT_ARM | waiting for link status 0 (drops last transaction's status)
// S_WAIT_RSP | collecting response bytes until link status is nonzero
// S_DONE     | one-cycle done pulse
// ---------------------------------------------------------------------------
module rs485_txn_ctrl
    import rs485_txn_pkg::*;
#(
    parameter int G_BUF_DEPTH  = LP_BUF_DEPTH,
    parameter int G_TMO_CYCLES = 1280000
)
(
    input  logic        p_in_clk,
    input  logic        p_in_rst_n,
    input  logic        p_in_start,
    input  logic [7:0]  p_in_dev_adr,
    input  logic [7:0]  p_in_dev_cmd,
    input  logic [4:0]  p_in_tx_len,
    input  logic        p_in_txbuf_wr,
    input  logic [3:0]  p_in_txbuf_adr,
    input  logic [7:0]  p_in_txbuf_d,
    output logic        p_out_txd_rdy,
    output logic [7:0]  p_out_txd,
    input  logic        p_in_txd_rd,
    input  logic [7:0]  p_in_rxd,
    input  logic        p_in_rxd_wr,
    input  logic [2:0]  p_in_link_status,
    input  logic [3:0]  p_in_rxbuf_adr,
    output logic [7:0]  p_out_rxbuf_d,
    output logic [4:0]  p_out_rx_len,
    output logic        p_out_busy,
    output logic        p_out_done,
    output logic [2:0]  p_out_result
);

    // Buffers are 16 deep; G_BUF_DEPTH may only lower the usable depth.
    localparam logic [4:0] LP_DEPTH = 5'(G_BUF_DEPTH);

    state_t      r_state;
    state_t      w_state_nxt;

    logic [7:0]  r_adr;
    logic [7:0]  r_cmd;
    logic [4:0]  r_len;
    logic [4:0]  r_tx_idx;
    logic [4:0]  w_tx_idx_nxt;
    logic [2:0]  r_err;
    logic [2:0]  w_err_nxt;
    logic [1:0]  r_hdr;
    logic [1:0]  w_hdr_nxt;
    logic [4:0]  r_rx_len;
    logic [4:0]  w_rx_len_nxt;
    logic [2:0]  r_result;
    logic [2:0]  w_result_nxt;

    logic        w_latch;
    logic        w_rx_take;
    logic        w_rxbuf_we;
    logic        w_tmo_hit;
    logic        w_txd_rdy;
    logic        w_busy;
    logic        w_done;

    logic [3:0]  w_tx_radr;
    logic [7:0]  w_tx_rdata;

    // -----------------------------------------------------------------------
    // Payload buffers
    // -----------------------------------------------------------------------
    // The TX read address follows the next byte index so that, with the
    // registered read, the payload byte is ready the cycle after a link rd.
    // Payload byte k sits at index k+2; wrap in 4 bits gives idx-2.
    assign w_tx_radr = w_tx_idx_nxt[3:0] - 4'd2;

    rs485_txn_buf u_txbuf (
        .p_in_clk (p_in_clk),
        .i_wr     (p_in_txbuf_wr),
        .i_wadr   (p_in_txbuf_adr),
        .i_wd     (p_in_txbuf_d),
        .i_radr   (w_tx_radr),
        .o_rd     (w_tx_rdata)
    );

    rs485_txn_buf u_rxbuf (
        .p_in_clk (p_in_clk),
        .i_wr     (w_rxbuf_we),
        .i_wadr   (r_rx_len[3:0]),
        .i_wd     (p_in_rxd),
        .i_radr   (p_in_rxbuf_adr),
        .o_rd     (p_out_rxbuf_d)
    );

    // -----------------------------------------------------------------------
    // Optional response timeout
    // -----------------------------------------------------------------------
`ifdef RS485_TXN_TMO_EN
    localparam int LP_TMO_W = (G_TMO_CYCLES > 2) ? $clog2(G_TMO_CYCLES) : 1;
    localparam logic [LP_TMO_W-1:0] LP_TMO_LAST = LP_TMO_W'(G_TMO_CYCLES - 1);

    logic [LP_TMO_W-1:0] r_tmo_cnt;

    always_ff @(posedge p_in_clk) begin
        if (!p_in_rst_n)
            r_tmo_cnt <= '0;
        else if ((r_state == S_WAIT_ARM || r_state == S_WAIT_RSP) && !p_in_rxd_wr)
            r_tmo_cnt <= r_tmo_cnt + LP_TMO_W'(1);
        else
            r_tmo_cnt <= '0;
    end

    // A byte arriving on the terminal cycle restarts the wait.
    assign w_tmo_hit = (r_tmo_cnt == LP_TMO_LAST) && !p_in_rxd_wr;
`else
    assign w_tmo_hit = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Response byte bookkeeping
    // -----------------------------------------------------------------------
    assign w_rx_take = (r_state == S_WAIT_RSP) && p_in_rxd_wr;

    always_comb begin
        w_hdr_nxt    = r_hdr;
        w_err_nxt    = r_err;
        w_rx_len_nxt = r_rx_len;
        w_rxbuf_we   = 1'b0;
        if (w_rx_take) begin
            if (r_hdr == 2'd0) begin
                w_hdr_nxt = 2'd1;
                if (p_in_rxd != r_adr && r_err == RES_OK)
                    w_err_nxt = RES_ADR;
            end else if (r_hdr == 2'd1) begin
                w_hdr_nxt = 2'd2;
                if (p_in_rxd != r_cmd && r_err == RES_OK)
                    w_err_nxt = RES_CMD;
            end else if (r_rx_len < LP_DEPTH) begin
                w_rxbuf_we   = 1'b1;
                w_rx_len_nxt = r_rx_len + 5'd1;
            end else if (r_err == RES_OK) begin
                w_err_nxt = RES_OVF;
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_tx_idx_nxt = r_tx_idx;
        w_result_nxt = r_result;
        w_latch      = 1'b0;
        w_txd_rdy    = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (p_in_start) begin
                    w_latch      = 1'b1;
                    w_tx_idx_nxt = 5'd0;
                    w_result_nxt = RES_OK;
                    w_state_nxt  = S_TX;
                end
            end
            S_TX: begin
                w_txd_rdy = 1'b1;
                w_busy    = 1'b1;
                if (p_in_txd_rd) begin
                    if (r_tx_idx == r_len + 5'd1)
                        w_state_nxt = S_WAIT_ARM;
                    else
                        w_tx_idx_nxt = r_tx_idx + 5'd1;
                end
            end
            S_WAIT_ARM: begin
                w_busy = 1'b1;
                if (p_in_link_status == LS_BUSY) begin
                    w_state_nxt = S_WAIT_RSP;
                end else if (w_tmo_hit) begin
                    w_result_nxt = RES_TMO;
                    w_state_nxt  = S_DONE;
                end
            end
            S_WAIT_RSP: begin
                w_busy = 1'b1;
                // Uses the post-byte error/count so a same-cycle byte is counted.
                if (p_in_link_status != LS_BUSY) begin
                    w_result_nxt = resolve_result(p_in_link_status, w_err_nxt, w_hdr_nxt);
                    w_state_nxt  = S_DONE;
                end else if (w_tmo_hit) begin
                    w_result_nxt = RES_TMO;
                    w_state_nxt  = S_DONE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge p_in_clk) begin
        if (!p_in_rst_n) begin
            r_state  <= S_IDLE;
            r_adr    <= '0;
            r_cmd    <= '0;
            r_len    <= '0;
            r_tx_idx <= '0;
            r_err    <= RES_OK;
            r_hdr    <= '0;
            r_rx_len <= '0;
            r_result <= RES_OK;
        end else begin
            r_state  <= w_state_nxt;
            r_tx_idx <= w_tx_idx_nxt;
            r_result <= w_result_nxt;
            if (w_latch) begin
                r_adr    <= p_in_dev_adr;
                r_cmd    <= p_in_dev_cmd;
                r_len    <= clamp_len(p_in_tx_len, LP_DEPTH);
                r_err    <= RES_OK;
                r_hdr    <= '0;
                r_rx_len <= '0;
            end else begin
                r_err    <= w_err_nxt;
                r_hdr    <= w_hdr_nxt;
                r_rx_len <= w_rx_len_nxt;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        p_out_txd = 8'h00;
        if (r_state == S_TX) begin
            if (r_tx_idx == 5'd0)
                p_out_txd = r_adr;
            else if (r_tx_idx == 5'd1)
                p_out_txd = r_cmd;
            else
                p_out_txd = w_tx_rdata;
        end
    end

    assign p_out_txd_rdy = w_txd_rdy;
    assign p_out_busy    = w_busy;
    assign p_out_done    = w_done;
    assign p_out_result  = r_result;
    assign p_out_rx_len  = r_rx_len;

endmodule

// File: tb/tb_rs485_txn_ctrl.sv
module tb_rs485_txn_ctrl;

    localparam int TMO = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] dev_adr, dev_cmd;
    logic [4:0] tx_len;
    logic       txbuf_wr;
    logic [3:0] txbuf_adr;
    logic [7:0] txbuf_d;
    logic       txd_rdy;
    logic [7:0] txd;
    logic       txd_rd;
    logic [7:0] rxd;
    logic       rxd_wr;
    logic [2:0] link_status;
    logic [3:0] rxbuf_adr;
    logic [7:0] rxbuf_d;
    logic [4:0] rx_len;
    logic       busy, done;
    logic [2:0] result;

    int checks = 0;
    int errors = 0;

    logic [7:0] tx_model [16];
    logic [7:0] exp_tx [$];
    logic [7:0] exp_rx [$];
    logic [2:0] exp_res [$];
    logic [7:0] rsp_q [$];
    logic [7:0] cur_adr, cur_cmd;

    always #5 clk = ~clk;

    rs485_txn_ctrl #(.G_BUF_DEPTH(16), .G_TMO_CYCLES(TMO)) dut (
        .p_in_clk         (clk),
        .p_in_rst_n       (rst_n),
        .p_in_start       (start),
        .p_in_dev_adr     (dev_adr),
        .p_in_dev_cmd     (dev_cmd),
        .p_in_tx_len      (tx_len),
        .p_in_txbuf_wr    (txbuf_wr),
        .p_in_txbuf_adr   (txbuf_adr),
        .p_in_txbuf_d     (txbuf_d),
        .p_out_txd_rdy    (txd_rdy),
        .p_out_txd        (txd),
        .p_in_txd_rd      (txd_rd),
        .p_in_rxd         (rxd),
        .p_in_rxd_wr      (rxd_wr),
        .p_in_link_status (link_status),
        .p_in_rxbuf_adr   (rxbuf_adr),
        .p_out_rxbuf_d    (rxbuf_d),
        .p_out_rx_len     (rx_len),
        .p_out_busy       (busy),
        .p_out_done       (done),
        .p_out_result     (result)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_tx(input logic [3:0] a, input logic [7:0] d);
        txbuf_wr  = 1'b1;
        txbuf_adr = a;
        txbuf_d   = d;
        tx_model[a] = d;
        @(negedge clk);
        txbuf_wr  = 1'b0;
    endtask

    task automatic start_txn(input logic [7:0] a, input logic [7:0] c, input logic [4:0] len);
        int n;
        cur_adr = a;
        cur_cmd = c;
        n = (len > 5'd16) ? 16 : int'(len);
        exp_tx.push_back(a);
        exp_tx.push_back(c);
        for (int i = 0; i < n; i++) exp_tx.push_back(tx_model[i]);
        start   = 1'b1;
        dev_adr = a;
        dev_cmd = c;
        tx_len  = len;
        @(negedge clk);
        start   = 1'b0;
        chk("start_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic drain_tx();
        int g;
        while (exp_tx.size() > 0) begin
            g = 0;
            while (!txd_rdy && g < 20) begin
                @(negedge clk);
                g++;
            end
            chk("txd_rdy", {31'd0, txd_rdy}, 32'd1);
            chk("txd_byte", {24'd0, txd}, {24'd0, exp_tx.pop_front()});
            txd_rd = 1'b1;
            @(negedge clk);
            txd_rd = 1'b0;
        end
        chk("txd_rdy_fall", {31'd0, txd_rdy}, 32'd0);
    endtask

    task automatic run_rsp(input logic [2:0] st);
        int n, cyc, k, plen;
        logic [2:0] err, res;
        link_status = 3'd0;
        @(negedge clk);
        n = rsp_q.size();
        err = 3'd0;
        if (n >= 1 && rsp_q[0] != cur_adr) err = 3'd2;
        if (n >= 2 && rsp_q[1] != cur_cmd && err == 3'd0) err = 3'd3;
        if (n > 18 && err == 3'd0) err = 3'd5;
        if (st == 3'd2)      res = 3'd1;
        else if (err != 0)   res = err;
        else if (n < 2)      res = 3'd6;
        else                 res = 3'd0;
        exp_res.push_back(res);
        plen = (n > 18) ? 16 : ((n > 2) ? n - 2 : 0);
        for (int i = 2; i < n && i < 18; i++) exp_rx.push_back(rsp_q[i]);
        for (int i = 0; i < n; i++) begin
            rxd    = rsp_q[i];
            rxd_wr = 1'b1;
            @(negedge clk);
            rxd_wr = 1'b0;
        end
        link_status = st;
        @(negedge clk);
        cyc = 1;
        while (!done && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("result", {29'd0, result}, {29'd0, exp_res.pop_front()});
        chk("rx_len", {27'd0, rx_len}, plen);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("result_held", {29'd0, result}, {29'd0, res});
        k = 0;
        while (exp_rx.size() > 0) begin
            rxbuf_adr = 4'(k);
            @(negedge clk);
            chk("rxbuf", {24'd0, rxbuf_d}, {24'd0, exp_rx.pop_front()});
            k++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst_n = 1'b0; start = 1'b0; dev_adr = '0; dev_cmd = '0; tx_len = '0;
        txbuf_wr = 1'b0; txbuf_adr = '0; txbuf_d = '0; txd_rd = 1'b0;
        rxd = '0; rxd_wr = 1'b0; link_status = 3'd1; rxbuf_adr = '0;
        for (int i = 0; i < 16; i++) tx_model[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_txd_rdy", {31'd0, txd_rdy}, 32'd0);
        chk("rst_txd", {24'd0, txd}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", {29'd0, result}, 32'd0);
        chk("rst_rx_len", {27'd0, rx_len}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic transaction, held status from before must not end the wait.
        write_tx(4'd0, 8'hAA);
        write_tx(4'd1, 8'h55);
        start_txn(8'h21, 8'h05, 5'd2);
        drain_tx();
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("held_status_no_done", cnt, 0);
        chk("held_status_busy", {31'd0, busy}, 32'd1);
        rsp_q = '{8'h21, 8'h05, 8'h0F};
        run_rsp(3'd1);

        // Address mismatch, zero-length request.
        start_txn(8'h21, 8'h05, 5'd0);
        drain_tx();
        rsp_q = '{8'h22, 8'h05, 8'h33};
        run_rsp(3'd1);

        // Command mismatch.
        start_txn(8'h21, 8'h05, 5'd1);
        drain_tx();
        rsp_q = '{8'h21, 8'h06};
        run_rsp(3'd1);

        // Parity error after bytes.
        start_txn(8'h21, 8'h05, 5'd2);
        drain_tx();
        rsp_q = '{8'h21, 8'h05, 8'h01};
        run_rsp(3'd2);

        // Overflow: 17 payload bytes, only 16 stored.
        start_txn(8'h21, 8'h05, 5'd0);
        drain_tx();
        rsp_q.delete();
        rsp_q.push_back(8'h21);
        rsp_q.push_back(8'h05);
        for (int i = 0; i < 17; i++) rsp_q.push_back(8'h80 + 8'(i));
        run_rsp(3'd1);

        // Short response: address only.
        start_txn(8'h21, 8'h05, 5'd0);
        drain_tx();
        rsp_q = '{8'h21};
        run_rsp(3'd1);

        // Length clamp to 16 and start while busy ignored.
        for (int i = 0; i < 16; i++) write_tx(4'(i), 8'h30 + 8'(i));
        start_txn(8'h5A, 8'hC3, 5'd20);
        start   = 1'b1;
        dev_adr = 8'h77;
        dev_cmd = 8'h11;
        tx_len  = 5'd3;
        @(negedge clk);
        start   = 1'b0;
        chk("busy_after_extra_start", {31'd0, busy}, 32'd1);
        drain_tx();
        rsp_q = '{8'h5A, 8'hC3};
        run_rsp(3'd1);

        // Reset during S_TX.
        start_txn(8'h21, 8'h05, 5'd2);
        chk("abort_first_byte", {24'd0, txd}, 32'h21);
        txd_rd = 1'b1;
        @(negedge clk);
        txd_rd = 1'b0;
        exp_tx.delete();
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_txd_rdy", {31'd0, txd_rdy}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_txd", {24'd0, txd}, 32'd0);
        rst_n = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("abort_no_done", cnt, 0);
        write_tx(4'd0, 8'hAA);
        write_tx(4'd1, 8'h55);
        start_txn(8'h21, 8'h05, 5'd2);
        drain_tx();
        rsp_q = '{8'h21, 8'h05, 8'h0F};
        run_rsp(3'd1);

`ifdef RS485_TXN_TMO_EN
        // No response: timeout counted from the first S_WAIT_ARM cycle.
        link_status = 3'd1;
        start_txn(8'h21, 8'h05, 5'd1);
        drain_tx();
        cnt = 0;
        while (!done && cnt < TMO + 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("tmo_latency", cnt, TMO);
        chk("tmo_result", {29'd0, result}, 32'd4);
        chk("tmo_busy", {31'd0, busy}, 32'd0);
`else
        // No response and no timeout: block keeps waiting.
        start_txn(8'h21, 8'h05, 5'd1);
        drain_tx();
        link_status = 3'd0;
        cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("no_tmo_no_done", cnt, 0);
        chk("no_tmo_busy", {31'd0, busy}, 32'd1);
        rsp_q.delete();
        run_rsp(3'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
